// File: rtl/uart_rx.sv
// UART receiver with 16x oversampling: start bit, DBIT data bits LSB first, no parity,
// and a stop bit of SB_TICK ticks. Each byte is presented on dout with a one-clk done strobe.
module uart_rx #(
    parameter int DBIT    = 8,
    parameter int SB_TICK = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            rx,
    input  logic            s_tick,
    output logic            rx_done_tick,
    output logic [DBIT-1:0] dout,
    output logic            frame_err
);

    localparam int SW = (SB_TICK > 16) ? 5 : 4;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t          state;
    logic [SW-1:0]   s_cnt;
    logic [2:0]      n_cnt;
    logic [DBIT-1:0] shift;
    logic            rx_meta;
    logic            rx_s;

    // rx is asynchronous to clk; both stages idle high so reset never looks like a start bit
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            s_cnt        <= '0;
            n_cnt        <= '0;
            shift        <= '0;
            dout         <= '0;
            rx_done_tick <= 1'b0;
            frame_err    <= 1'b0;
        end else begin
            rx_done_tick <= 1'b0;
            case (state)
                IDLE: begin
                    if (!rx_s) begin
                        state <= START;
                        s_cnt <= '0;
                    end
                end
                START: begin
                    // Re-check the line half a bit in to reject glitches
                    if (s_tick) begin
                        if (s_cnt == SW'(7)) begin
                            if (!rx_s) begin
                                state <= DATA;
                                s_cnt <= '0;
                                n_cnt <= '0;
                            end else begin
                                state <= IDLE;
                            end
                        end else begin
                            s_cnt <= s_cnt + SW'(1);
                        end
                    end
                end
                DATA: begin
                    if (s_tick) begin
                        if (s_cnt == SW'(15)) begin
                            s_cnt <= '0;
                            shift <= {rx_s, shift[DBIT-1:1]};
                            if (n_cnt == 3'(DBIT - 1)) begin
                                state <= STOP;
                            end else begin
                                n_cnt <= n_cnt + 3'd1;
                            end
                        end else begin
                            s_cnt <= s_cnt + SW'(1);
                        end
                    end
                end
                STOP: begin
                    if (s_tick) begin
                        if (s_cnt == SW'(SB_TICK - 1)) begin
                            state        <= IDLE;
                            dout         <= shift;
                            frame_err    <= ~rx_s;
                            rx_done_tick <= 1'b1;
                        end else begin
                            s_cnt <= s_cnt + SW'(1);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Table-driven bench for uart_rx: s_tick every 4th clk, 64 clk per bit, plus
// hand-written glitch and mid-frame reset sequences.
module tb_uart_rx;

    localparam int BIT_CLK     = 64;
    localparam int STROBE_LAT  = 609;

    typedef struct {
        logic [7:0] data;
        logic       stop_val;
        int         stop_len;
        int         idle_len;
        logic [7:0] exp_dout;
        logic       exp_ferr;
    } vec_t;

    typedef struct {
        logic [7:0] d;
        logic       fe;
        int         c;
    } strobe_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       rx = 1'b1;
    logic       s_tick;
    logic       rx_done_tick;
    logic [7:0] dout;
    logic       frame_err;

    logic [1:0] tick_div = 2'd0;
    int         cyc = 0;
    int         start_cyc = 0;
    int         compared = 0;
    int         mismatched = 0;
    int         dbl_cnt = 0;
    logic       prev_done = 1'b0;
    strobe_t    q[$];
    vec_t       vecs[6];

    uart_rx #(.DBIT(8), .SB_TICK(16)) dut (
        .clk          (clk),
        .reset        (reset),
        .rx           (rx),
        .s_tick       (s_tick),
        .rx_done_tick (rx_done_tick),
        .dout         (dout),
        .frame_err    (frame_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        tick_div <= tick_div + 2'd1;
        cyc      <= cyc + 1;
    end

    assign s_tick = (tick_div == 2'd3);

    // Log every strobe with its edge count so latency and back-to-back strobes can be checked
    always @(negedge clk) begin
        if (rx_done_tick === 1'b1) begin
            q.push_back('{dout, frame_err, cyc});
            if (prev_done) dbl_cnt++;
        end
        prev_done = (rx_done_tick === 1'b1);
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        compared++;
        if (actual != expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Starts on a negedge where the next edge carries s_tick, so latency is exact
    task automatic applyStimulus(input logic [7:0] data, input logic stop_val,
                                 input int stop_len, input int idle_len);
        while (tick_div != 2'd3) @(negedge clk);
        start_cyc = cyc;
        rx = 1'b0;
        repeat (BIT_CLK) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = data[i];
            repeat (BIT_CLK) @(negedge clk);
        end
        rx = stop_val;
        repeat (stop_len) @(negedge clk);
        rx = 1'b1;
        repeat (BIT_CLK - stop_len + idle_len) @(negedge clk);
    endtask

    task automatic checkFrame(input string name, input logic [7:0] exp_dout, input logic exp_ferr);
        strobe_t s;
        checkOutput({name, " strobe count"}, q.size(), 1);
        if (q.size() > 0) begin
            s = q.pop_front();
            checkOutput({name, " dout"}, int'(s.d), int'(exp_dout));
            checkOutput({name, " frame_err"}, int'(s.fe), int'(exp_ferr));
            checkOutput({name, " latency"}, s.c - start_cyc, STROBE_LAT);
        end
        q.delete();
    endtask

    initial begin
        logic [7:0] abort_data;

        vecs[0] = '{8'hA5, 1'b1, 64, 64, 8'hA5, 1'b0};
        vecs[1] = '{8'h00, 1'b1, 64, 0,  8'h00, 1'b0};
        vecs[2] = '{8'hFF, 1'b1, 64, 0,  8'hFF, 1'b0};
        vecs[3] = '{8'h3C, 1'b1, 64, 64, 8'h3C, 1'b0};
        vecs[4] = '{8'h81, 1'b0, 48, 64, 8'h81, 1'b1};
        vecs[5] = '{8'h42, 1'b1, 64, 64, 8'h42, 1'b0};

        repeat (2) @(negedge clk);
        reset = 1'b0;
        checkOutput("reset dout", int'(dout), 0);
        checkOutput("reset frame_err", int'(frame_err), 0);
        checkOutput("reset rx_done_tick", int'(rx_done_tick), 0);
        repeat (200) @(negedge clk);
        checkOutput("idle strobes", q.size(), 0);

        for (int v = 0; v < 6; v++) begin
            applyStimulus(vecs[v].data, vecs[v].stop_val, vecs[v].stop_len, vecs[v].idle_len);
            checkFrame($sformatf("vec%0d", v), vecs[v].exp_dout, vecs[v].exp_ferr);
        end

        rx = 1'b0;
        repeat (16) @(negedge clk);
        rx = 1'b1;
        repeat (200) @(negedge clk);
        checkOutput("glitch strobes", q.size(), 0);
        applyStimulus(8'h5A, 1'b1, 64, 64);
        checkFrame("after glitch", 8'h5A, 1'b0);

        // Abort 0xC3 halfway through data bit 4
        abort_data = 8'hC3;
        while (tick_div != 2'd3) @(negedge clk);
        rx = 1'b0;
        repeat (BIT_CLK) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            rx = abort_data[i];
            repeat (BIT_CLK) @(negedge clk);
        end
        rx = abort_data[4];
        repeat (BIT_CLK / 2) @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        rx = 1'b1;
        repeat (200) @(negedge clk);
        checkOutput("abort strobes", q.size(), 0);
        checkOutput("abort dout", int'(dout), 0);
        checkOutput("abort frame_err", int'(frame_err), 0);
        applyStimulus(8'h99, 1'b1, 64, 64);
        checkFrame("after abort", 8'h99, 1'b0);

        checkOutput("double strobes", dbl_cnt, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
